// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl: 68000 bus-cycle controller between the fx68k wrapper and the
// address decoders. It produces nDTACK after per-region wait states, with an
// optional MEM_READY handshake. It produces nVPA for FC-qualified
// interrupt-acknowledge cycles.
// Optional feature: define M68K_BUS_TIMEOUT_EN to add a bus-timeout watchdog.
// With the watchdog, nBERR is driven and unmapped cycles fault immediately.
// Without it, nBERR is tied high.
module m68k_bus_ctrl #(
  parameter int              NREG       = 4,
  parameter int              WW         = 4,
  parameter logic [NREG-1:0] READY_MASK = '0,
  parameter int              DEF_WAIT   = 2,
  parameter int              TIMEOUT    = 255
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               CLK_EN_68K_P,
  input  logic               CLK_EN_68K_N,
  input  logic               nAS,
  input  logic               M68K_RW,
  input  logic [2:0]         FC,
  input  logic [23:1]        M68K_ADDR,
  input  logic [NREG-1:0]    REGION_SEL,
  input  logic [NREG*WW-1:0] REGION_WAIT,
  input  logic               MEM_READY,
  output logic               nDTACK,
  output logic               nVPA,
  output logic               nBERR,
  output logic [2:0]         IACK_LEVEL,
  output logic               CYCLE_START,
  output logic               BUSY
);

  localparam logic [WW-1:0] DEF_WAIT_V = WW'(DEF_WAIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY,
    ST_ACK,
    ST_IACK,
    ST_BERR
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          ready_req;
  logic          armed;
  logic          is_iack;
  logic          sel_hit;
  logic [WW-1:0] sel_wait;
  logic          sel_ready;

  // PHI1 enable and R/W do not influence cycle timing.
  logic unused_inputs;
  assign unused_inputs = ^{CLK_EN_68K_P, M68K_RW};

  // An interrupt acknowledge needs CPU space (FC=7) and the all-ones upper address.
  assign is_iack = (FC == 3'b111) && (&M68K_ADDR[23:4]);

`ifdef M68K_BUS_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt;
`else
  assign nBERR = 1'b1;
`endif

  // Lowest-index selected region wins: scan downward so the last hit is the lowest.
  always_comb begin
    sel_hit   = 1'b0;
    sel_wait  = '0;
    sel_ready = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (REGION_SEL[i]) begin
        sel_hit   = 1'b1;
        sel_wait  = REGION_WAIT[i*WW +: WW];
        sel_ready = READY_MASK[i];
      end
    end
  end

  // Bus-cycle FSM; all state and outputs advance only on PHI2-enabled edges.
  // The 'armed' flag requires nAS to be seen high after reset before a cycle starts.
  // The watchdog is checked before the wait count, so a timeout wins over an ack on the same enable.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state       <= ST_IDLE;
      nDTACK      <= 1'b1;
      nVPA        <= 1'b1;
      IACK_LEVEL  <= 3'd0;
      CYCLE_START <= 1'b0;
      BUSY        <= 1'b0;
      wait_cnt    <= '0;
      ready_req   <= 1'b0;
      armed       <= 1'b0;
`ifdef M68K_BUS_TIMEOUT_EN
      nBERR       <= 1'b1;
      wd_cnt      <= 8'd0;
`endif
    end else begin
      CYCLE_START <= 1'b0;
      if (CLK_EN_68K_N) begin
        if (nAS) armed <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (!nAS && armed) begin
              CYCLE_START <= 1'b1;
              BUSY        <= 1'b1;
              wait_cnt    <= sel_hit ? sel_wait : DEF_WAIT_V;
              ready_req   <= sel_hit & sel_ready;
`ifdef M68K_BUS_TIMEOUT_EN
              wd_cnt      <= 8'd0;
`endif
              if (is_iack) begin
                state      <= ST_IACK;
                nVPA       <= 1'b0;
                IACK_LEVEL <= M68K_ADDR[3:1];
              end
`ifdef M68K_BUS_TIMEOUT_EN
              else if (!sel_hit) begin
                state <= ST_BERR;
                nBERR <= 1'b0;
              end
`endif
              else begin
                state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
`ifdef M68K_BUS_TIMEOUT_EN
            wd_cnt <= wd_cnt + 8'd1;
`endif
            if (nAS) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
`ifdef M68K_BUS_TIMEOUT_EN
            else if (wd_cnt == WD_LAST) begin
              state <= ST_BERR;
              nBERR <= 1'b0;
            end
`endif
            else if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
            end else if (ready_req) begin
              state <= ST_READY;
            end else begin
              state  <= ST_ACK;
              nDTACK <= 1'b0;
            end
          end
          ST_READY: begin
`ifdef M68K_BUS_TIMEOUT_EN
            wd_cnt <= wd_cnt + 8'd1;
`endif
            if (nAS) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
`ifdef M68K_BUS_TIMEOUT_EN
            else if (wd_cnt == WD_LAST) begin
              state <= ST_BERR;
              nBERR <= 1'b0;
            end
`endif
            else if (MEM_READY) begin
              state  <= ST_ACK;
              nDTACK <= 1'b0;
            end
          end
          ST_ACK: begin
            if (nAS) begin
              nDTACK <= 1'b1;
              state  <= ST_IDLE;
              BUSY   <= 1'b0;
            end
          end
          ST_IACK: begin
            if (nAS) begin
              nVPA       <= 1'b1;
              IACK_LEVEL <= 3'd0;
              state      <= ST_IDLE;
              BUSY       <= 1'b0;
            end
          end
          ST_BERR: begin
            if (nAS) begin
`ifdef M68K_BUS_TIMEOUT_EN
              nBERR <= 1'b1;
`endif
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// tb_m68k_bus_ctrl: self-checking bench for m68k_bus_ctrl.
// The reference model predicts two things for each bus cycle. First, the PHI2
// enable at which the acknowledge appears. Second, the kind of acknowledge.
// Expected outputs at every enable then follow from that prediction and the
// nAS hold time.
// The bench honours M68K_BUS_TIMEOUT_EN in the same way as the design.
module tb_m68k_bus_ctrl;

  localparam int         NREG  = 4;
  localparam int         WW    = 4;
  localparam logic [3:0] RMASK = 4'b0010;
  localparam int         DEFW  = 2;
  localparam int         TO    = 8;
`ifdef M68K_BUS_TIMEOUT_EN
  localparam bit FEATURE = 1'b1;
`else
  localparam bit FEATURE = 1'b0;
`endif

  localparam int K_DT   = 0;
  localparam int K_VPA  = 1;
  localparam int K_BERR = 2;

  logic        CLK;
  logic        nRESET;
  logic        CLK_EN_68K_P;
  logic        CLK_EN_68K_N;
  logic        nAS;
  logic        M68K_RW;
  logic [2:0]  FC;
  logic [23:1] M68K_ADDR;
  logic [3:0]  REGION_SEL;
  logic [15:0] REGION_WAIT;
  logic        MEM_READY;
  logic        nDTACK;
  logic        nVPA;
  logic        nBERR;
  logic [2:0]  IACK_LEVEL;
  logic        CYCLE_START;
  logic        BUSY;

  int checks;
  int errors;
  logic [1:0] div;

  m68k_bus_ctrl #(
    .NREG(NREG), .WW(WW), .READY_MASK(RMASK), .DEF_WAIT(DEFW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_EN_68K_P(CLK_EN_68K_P), .CLK_EN_68K_N(CLK_EN_68K_N),
    .nAS(nAS), .M68K_RW(M68K_RW), .FC(FC), .M68K_ADDR(M68K_ADDR),
    .REGION_SEL(REGION_SEL), .REGION_WAIT(REGION_WAIT), .MEM_READY(MEM_READY),
    .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR), .IACK_LEVEL(IACK_LEVEL),
    .CYCLE_START(CYCLE_START), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // PHI2 enable on one CLK out of four, PHI1 enable halfway between.
  always @(negedge CLK) begin
    div          = div + 2'd1;
    CLK_EN_68K_N = (div == 2'd3);
    CLK_EN_68K_P = (div == 2'd1);
  end

  // Absolute time limit so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL sim_timeout got running exp finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h exp %0h", tag, observed, expected);
    end
  endtask

  // Wait for the next PHI2-enabled edge, then settle 1 time unit past it.
  task automatic stepEnable();
    do @(posedge CLK); while (!CLK_EN_68K_N);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [15:0] waits,
                               input logic [2:0] fc, input logic [23:1] addr);
    REGION_SEL  = sel;
    REGION_WAIT = waits;
    FC          = fc;
    M68K_ADDR   = addr;
    M68K_RW     = 1'($urandom_range(0, 1));
    MEM_READY   = 1'b0;
    nAS         = 1'b0;
  endtask

  // Reference model: enable index (0 = acceptance) at which the acknowledge starts.
  task automatic predictCycle(input logic [3:0] sel, input logic [15:0] waits,
                              input logic [2:0] fc, input logic [23:1] addr,
                              input int rdy_at, output int start, output int kind,
                              output bit iack);
    bit mapped;
    int k;
    int w;
    bit rdy;
    mapped = 1'b0;
    k      = 0;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i]) begin
        mapped = 1'b1;
        k      = i;
      end
    end
    iack = (fc == 3'b111) && (addr[23:4] == 20'hFFFFF);
    if (iack) begin
      kind  = K_VPA;
      start = 0;
    end else if (!mapped && FEATURE) begin
      kind  = K_BERR;
      start = 0;
    end else begin
      w     = mapped ? int'(waits[k*4 +: 4]) : DEFW;
      rdy   = mapped && RMASK[k];
      start = rdy ? ((rdy_at > w + 2) ? rdy_at : w + 2) : w + 1;
      kind  = K_DT;
      if (FEATURE && start >= TO) begin
        kind  = K_BERR;
        start = TO;
      end
    end
  endtask

  // Runs one bus cycle. nAS stays low through enable 'hold' and is sampled high at hold+1.
  // MEM_READY is first sampled high at enable rdy_at.
  task automatic runCycle(input string name, input logic [3:0] sel, input logic [15:0] waits,
                          input logic [2:0] fc, input logic [23:1] addr,
                          input int rdy_at, input int hold);
    int  start;
    int  kind;
    bit  iack;
    bit  active;
    predictCycle(sel, waits, fc, addr, rdy_at, start, kind, iack);
    applyStimulus(sel, waits, fc, addr);
    for (int j = 0; j <= hold + 1; j++) begin
      stepEnable();
      active = (hold >= start) && (j >= start) && (j <= hold);
      checkOutput($sformatf("%s_ndtack_e%0d", name, j), nDTACK, !(active && kind == K_DT));
      checkOutput($sformatf("%s_nvpa_e%0d", name, j), nVPA, !(active && kind == K_VPA));
      checkOutput($sformatf("%s_nberr_e%0d", name, j), nBERR, !(active && kind == K_BERR));
      checkOutput($sformatf("%s_busy_e%0d", name, j), BUSY, (j <= hold));
      checkOutput($sformatf("%s_lvl_e%0d", name, j), IACK_LEVEL,
                  (iack && j <= hold) ? addr[3:1] : 3'd0);
      checkOutput($sformatf("%s_cstart_e%0d", name, j), CYCLE_START, (j == 0));
      if (j == 0) begin
        @(posedge CLK);
        #1;
        checkOutput($sformatf("%s_cstart_pulse", name), CYCLE_START, 1'b0);
        REGION_SEL  = 4'($urandom);
        REGION_WAIT = 16'($urandom);
      end
      MEM_READY = (j + 1 >= rdy_at);
      nAS       = (j + 1 > hold);
    end
  endtask

  initial begin
    int          start;
    int          kind;
    bit          iack;
    int          r;
    int          hold;
    int          rdy_at;
    logic [3:0]  sel;
    logic [15:0] waits;
    logic [2:0]  fc;
    logic [23:1] addr;

    checks       = 0;
    errors       = 0;
    div          = 2'd0;
    CLK_EN_68K_N = 1'b0;
    CLK_EN_68K_P = 1'b0;
    nRESET       = 1'b0;
    nAS          = 1'b1;
    M68K_RW      = 1'b1;
    FC           = 3'd0;
    M68K_ADDR    = '0;
    REGION_SEL   = '0;
    REGION_WAIT  = '0;
    MEM_READY    = 1'b0;

    #23;
    checkOutput("rst_ndtack", nDTACK, 1'b1);
    checkOutput("rst_nvpa", nVPA, 1'b1);
    checkOutput("rst_nberr", nBERR, 1'b1);
    checkOutput("rst_lvl", IACK_LEVEL, 3'd0);
    checkOutput("rst_cstart", CYCLE_START, 1'b0);
    checkOutput("rst_busy", BUSY, 1'b0);
    #4 nRESET = 1'b1;
    stepEnable();
    stepEnable();

    // Directed cycles taken from the behaviour description.
    runCycle("wait3", 4'b0100, 16'h0300, 3'b101, 23'h001000, 1, 6);
    runCycle("ready", 4'b0110, 16'h0000, 3'b101, 23'h002000, 6, 8);
    runCycle("iack5", 4'b0001, 16'h0000, 3'b111, 23'h7FFFFD, 1, 3);
    runCycle("fc101", 4'b0001, 16'h0001, 3'b101, 23'h7FFFFD, 1, 4);
    runCycle("abort", 4'b0001, 16'h000A, 3'b110, 23'h000100, 1, 2);
    runCycle("stuck", 4'b0010, 16'h0000, 3'b101, 23'h000200, 30, (FEATURE ? 9 : 31));
    runCycle("unmap", 4'b0000, 16'hFFFF, 3'b101, 23'h000300, 1, 4);

    // An nAS pulse that falls and rises between two enables must never start a cycle.
    @(posedge CLK);
    #1 nAS = 1'b0;
    @(posedge CLK);
    #1 nAS = 1'b1;
    stepEnable();
    checkOutput("glitch_busy", BUSY, 1'b0);
    checkOutput("glitch_cstart", CYCLE_START, 1'b0);
    checkOutput("glitch_ndtack", nDTACK, 1'b1);

    // Reset during ACK: immediate release, and no new cycle until nAS is seen high.
    applyStimulus(4'b0001, 16'h0000, 3'b101, 23'h000400);
    stepEnable();
    checkOutput("rack_cstart", CYCLE_START, 1'b1);
    stepEnable();
    checkOutput("rack_ndtack_low", nDTACK, 1'b0);
    #3 nRESET = 1'b0;
    #1;
    checkOutput("rack_ndtack", nDTACK, 1'b1);
    checkOutput("rack_busy", BUSY, 1'b0);
    checkOutput("rack_nvpa", nVPA, 1'b1);
    checkOutput("rack_cstart0", CYCLE_START, 1'b0);
    #3 nRESET = 1'b1;
    for (int j = 0; j < 3; j++) begin
      stepEnable();
      checkOutput($sformatf("rack_post_ndtack_e%0d", j), nDTACK, 1'b1);
      checkOutput($sformatf("rack_post_busy_e%0d", j), BUSY, 1'b0);
    end
    nAS = 1'b1;
    stepEnable();
    runCycle("after_rst", 4'b1000, 16'h1000, 3'b001, 23'h000500, 1, 3);

    // Randomized cycles against the reference model.
    for (int t = 0; t < 60; t++) begin
      r      = $urandom_range(0, 9);
      waits  = 16'h0;
      for (int f = 0; f < 4; f++) waits[f*4 +: 4] = 4'($urandom_range(0, 6));
      rdy_at = $urandom_range(1, 12);
      sel    = 4'($urandom_range(1, 15));
      fc     = 3'($urandom_range(0, 6));
      addr   = 23'($urandom);
      if (r <= 1) begin
        fc   = 3'b111;
        addr = {20'hFFFFF, 3'($urandom)};
      end else if (r == 2) begin
        addr = {20'hFFFFF, 3'($urandom)};
        if ($urandom_range(0, 1) == 1) begin
          fc = 3'b111;
          addr[$urandom_range(4, 23)] = 1'b0;
        end
      end else if (r == 3) begin
        sel = 4'b0000;
      end
      predictCycle(sel, waits, fc, addr, rdy_at, start, kind, iack);
      if (start > 0 && $urandom_range(0, 4) == 0) hold = $urandom_range(0, start - 1);
      else hold = start + $urandom_range(0, 3);
      runCycle($sformatf("rnd%0d", t), sel, waits, fc, addr, rdy_at, hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
- Parametrised 68000 bus-cycle controller between the fx68k wrapper and the memory/peripheral decoders.
- Generates nDTACK with per-region programmable wait states and an optional external ready handshake.
- Generates nVPA only during true interrupt-acknowledge cycles, qualified by the FC lines rather than by address alone.
- With the optional feature compiled in, it also generates nBERR through a bus-timeout watchdog.

Parameters:
NREG, 4, number of decoded regions (1..16)
WW, 4, width of each region's wait-state field
READY_MASK, 4'b0000, bit i=1: region i also waits for MEM_READY after its wait count expires
DEF_WAIT, 2, wait states for unmapped accesses (no REGION_SEL bit set)
TIMEOUT, 255, watchdog limit in PHI2 enables (8-bit counter, 1..255)

Ports:
CLK  in  1  system clock
nRESET  in  1  asynchronous active-low reset
CLK_EN_68K_P  in  1  PHI1 clock enable (unused except pass-through timing reference)
CLK_EN_68K_N  in  1  PHI2 clock enable; all state updates occur only on CLK cycles where this is 1
nAS  in  1  CPU address strobe
M68K_RW  in  1  CPU read/write
FC  in  3  CPU function code {FC2,FC1,FC0}
M68K_ADDR  in  23  CPU address [23:1]
REGION_SEL  in  NREG  one-hot region decode from address decoder
REGION_WAIT  in  NREG*WW  packed wait counts, region i at [i*WW +: WW]
MEM_READY  in  1  external ready for READY_MASK regions
nDTACK  out  1  data acknowledge to CPU
nVPA  out  1  autovector request to CPU
nBERR  out  1  bus error to CPU
IACK_LEVEL  out  3  level being acknowledged (valid while nVPA low)
CYCLE_START  out  1  one-CLK pulse when a bus cycle is accepted
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (nRESET low, async): state=IDLE; nDTACK=1, nVPA=1, nBERR=1, IACK_LEVEL=0, CYCLE_START=0, BUSY=0; counters cleared. Reset mid-cycle abandons the cycle; no ack is issued after release until a fresh nAS fall.
- States: IDLE, WAIT, READY, ACK, IACK, BERR.
- IDLE: on a PHI2 enable with nAS=0, classify, pulse CYCLE_START for that CLK, and load the counter.
  - IACK if FC==3'b111 and M68K_ADDR[23:4] all ones: latch IACK_LEVEL=M68K_ADDR[3:1], go IACK.
  - Otherwise pick the lowest-index set REGION_SEL bit k and load wait=REGION_WAIT[k]; if no bit is set, load wait=DEF_WAIT and mark the cycle unmapped. Go WAIT.
- WAIT: decrement once per PHI2 enable.
  - At wait==0: go READY if READY_MASK[k]=1, else go ACK.
  - Wait of 0 goes to ACK/READY on the next PHI2 enable, so minimum latency is one PHI2 enable after acceptance.
- READY: go ACK on the first PHI2 enable with MEM_READY=1.
- ACK: nDTACK=0, held until a PHI2 enable sees nAS=1; then nDTACK=1 and go IDLE.
- IACK: nVPA=0 on entry, held until a PHI2 enable sees nAS=1; then nVPA=1, IACK_LEVEL=0, go IDLE. nDTACK is never asserted in an IACK cycle.
- Abort: nAS=1 seen in WAIT or READY returns to IDLE with no acknowledge asserted.
- nDTACK, nVPA and nBERR are mutually exclusive; at most one is low at any time.
- Outputs are registered and change only on PHI2-enabled edges, except on reset.
- nAS falling and rising between two PHI2 enables is never seen; no cycle starts.
- REGION_SEL is sampled only at acceptance; later changes are ignored.

Optional Feature:
- Macro: M68K_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog clears at acceptance and increments per PHI2 enable in WAIT/READY.
  - At TIMEOUT, go BERR: nBERR=0 until a PHI2 enable sees nAS=1, then IDLE.
  - Unmapped cycles go directly from IDLE to BERR on acceptance instead of using DEF_WAIT.
  - The watchdog does not run in ACK or IACK.
- Undefined: no watchdog logic; nBERR is constant 1; unmapped cycles use DEF_WAIT; READY waits indefinitely.

Test Plan:
- Read with REGION_SEL=4'b0010 and wait field 3: nDTACK low on the 4th PHI2 enable after CYCLE_START, released on the first PHI2 enable after nAS high.
- REGION_SEL=4'b0110, READY_MASK=4'b0010, wait 0, MEM_READY held low for 5 PHI2 enables then high: region 1 wins; nDTACK low one PHI2 enable after MEM_READY rises.
- FC=3'b111, ADDR=23'h7FFFFD: nVPA low, IACK_LEVEL=3'd5, nDTACK stays 1. Repeat with FC=3'b101 at the same address: normal region cycle, nVPA stays 1.
- nAS raised during WAIT (wait field 10, raised after 2 enables): return to IDLE, nDTACK never low, BUSY low on the next PHI2 enable.
- nRESET pulsed low during ACK: all outputs return to 1/0 immediately, no ack after release until a new nAS fall.
- With M68K_BUS_TIMEOUT_EN, TIMEOUT=8, READY region and MEM_READY stuck low: nBERR low 8 PHI2 enables after acceptance. Unmapped access goes directly to BERR. Without the macro, nBERR stays 1 throughout.
